// File: rtl/gfx_op_dispatcher.sv
// rtl/gfx_op_dispatcher.sv - op FIFO with opcode decode routing heads to circle/line engines
// Invalid-opcode heads are discarded in one cycle and counted in a saturating counter.
module gfx_op_dispatcher #(
  parameter int         DEPTH      = 4,
  parameter int         OP_W       = 42,
  parameter logic [3:0] CIRCLE_OPC = 4'hC,
  parameter logic [3:0] LINE_OPC   = 4'hA
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic [OP_W-1:0]         in_op,
  input  logic                    in_rts,
  output logic                    in_rtr,
  output logic [OP_W-1:0]         circ_op,
  output logic                    circ_rts,
  input  logic                    circ_rtr,
  output logic [OP_W-1:0]         line_op,
  output logic                    line_rts,
  input  logic                    line_rtr,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [7:0]              drop_cnt
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  logic [OP_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [OP_W-1:0] head;
  logic [3:0]      head_opc;
  logic            not_empty;
  logic            is_circ;
  logic            is_line;
  logic            drop;
  logic            push;
  logic            pop;

  assign head      = mem[rd_ptr];
  assign head_opc  = head[3:0];
  assign not_empty = (fifo_count != '0);
  assign is_circ   = not_empty && (head_opc == CIRCLE_OPC);
  assign is_line   = not_empty && (head_opc == LINE_OPC);
  assign drop      = not_empty && !is_circ && !is_line;

  assign circ_op  = head;
  assign line_op  = head;
  assign circ_rts = is_circ;
  assign line_rts = is_line;

  // Full check uses only the registered count, so a same-cycle pop never frees a slot early.
  assign in_rtr = rst_ && (fifo_count != FULL);
  assign push   = in_rts && in_rtr;
  assign pop    = (is_circ && circ_rtr) || (is_line && line_rtr) || drop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_op;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_cnt   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (pop && !push) begin
        fifo_count <= fifo_count - 1'b1;
      end
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_gfx_op_dispatcher.sv
// tb/tb_gfx_op_dispatcher.sv - directed and randomized checks of gfx_op_dispatcher
module tb_gfx_op_dispatcher;

  localparam int DEPTH = 4;
  localparam int OP_W  = 42;

  logic            clk = 1'b0;
  logic            rst_;
  logic [OP_W-1:0] in_op;
  logic            in_rts;
  logic            in_rtr;
  logic [OP_W-1:0] circ_op;
  logic            circ_rts;
  logic            circ_rtr;
  logic [OP_W-1:0] line_op;
  logic            line_rts;
  logic            line_rtr;
  logic [2:0]      fifo_count;
  logic [7:0]      drop_cnt;

  int total = 0;
  int bad   = 0;

  gfx_op_dispatcher #(.DEPTH(DEPTH), .OP_W(OP_W), .CIRCLE_OPC(4'hC), .LINE_OPC(4'hA)) dut (
    .clk(clk), .rst_(rst_), .in_op(in_op), .in_rts(in_rts), .in_rtr(in_rtr),
    .circ_op(circ_op), .circ_rts(circ_rts), .circ_rtr(circ_rtr),
    .line_op(line_op), .line_rts(line_rts), .line_rtr(line_rtr),
    .fifo_count(fifo_count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [OP_W-1:0] mk_op(int xc, int yc, int r, int color, logic [3:0] opc);
    return {10'(xc), 10'(yc), 10'(r), 8'(color), opc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ = 1'b0; in_rts = 1'b0; in_op = '0; circ_rtr = 1'b0; line_rtr = 1'b0;
    step(); step();
    #2;
    total++; if (in_rtr !== 1'b0) begin bad++; $display("FAIL reset_in_rtr got=%0h want=0", in_rtr); end
    total++; if (circ_rts !== 1'b0) begin bad++; $display("FAIL reset_circ_rts got=%0h want=0", circ_rts); end
    total++; if (line_rts !== 1'b0) begin bad++; $display("FAIL reset_line_rts got=%0h want=0", line_rts); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
    rst_ = 1'b1;
    #1;
    total++; if (in_rtr !== 1'b1) begin bad++; $display("FAIL release_in_rtr got=%0h want=1", in_rtr); end
    step();
  endtask

  task automatic test_single_circle();
    logic [OP_W-1:0] op;
    op = 42'b0001100100_0001100100_0000001010_10101011_1100;
    circ_rtr = 1'b1; line_rtr = 1'b1;
    total++; if (circ_rts !== 1'b0) begin bad++; $display("FAIL single_pre_rts got=%0h want=0", circ_rts); end
    in_op = op; in_rts = 1'b1;
    step();
    in_rts = 1'b0;
    total++; if (circ_rts !== 1'b1) begin bad++; $display("FAIL single_rts got=%0h want=1", circ_rts); end
    total++; if (circ_op !== op) begin bad++; $display("FAIL single_op got=%h want=%h", circ_op, op); end
    total++; if (line_rts !== 1'b0) begin bad++; $display("FAIL single_line_rts got=%0h want=0", line_rts); end
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL single_count1 got=%0d want=1", fifo_count); end
    step();
    total++; if (circ_rts !== 1'b0) begin bad++; $display("FAIL single_rts_off got=%0h want=0", circ_rts); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL single_count0 got=%0d want=0", fifo_count); end
    total++; if (line_rts !== 1'b0) begin bad++; $display("FAIL single_line_rts2 got=%0h want=0", line_rts); end
  endtask

  task automatic test_back_to_back();
    logic [OP_W-1:0] op;
    op = 42'b0001100100_0001100100_0000001010_10101011_1100;
    circ_rtr = 1'b0;
    in_op = op; in_rts = 1'b1;
    step(); step();
    in_rts = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL b2b_stall_count c%0d got=%0d want=2", i, fifo_count); end
      total++; if (circ_rts !== 1'b1 || circ_op !== op) begin bad++; $display("FAIL b2b_stall_head c%0d got=%0h/%h want=1/%h", i, circ_rts, circ_op, op); end
      step();
    end
    circ_rtr = 1'b1;
    step();
    total++; if (fifo_count !== 3'd1 || circ_rts !== 1'b1) begin bad++; $display("FAIL b2b_first got=%0d/%0h want=1/1", fifo_count, circ_rts); end
    step();
    total++; if (fifo_count !== 3'd0 || circ_rts !== 1'b0) begin bad++; $display("FAIL b2b_second got=%0d/%0h want=0/0", fifo_count, circ_rts); end
  endtask

  task automatic test_fill_wrap();
    logic [OP_W-1:0] ops [6];
    logic [OP_W-1:0] got [$];
    int idx;
    for (int i = 0; i < 6; i++) ops[i] = mk_op(i + 1, 50, 5, 8'h11, 4'hC);
    circ_rtr = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 60 && got.size() < 6; cyc++) begin
      if (cyc == 8) begin
        total++; if (in_rtr !== 1'b0) begin bad++; $display("FAIL fill_in_rtr got=%0h want=0", in_rtr); end
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d want=4", fifo_count); end
        total++; if (idx != 4) begin bad++; $display("FAIL fill_accepted got=%0d want=4", idx); end
        circ_rtr = 1'b1;
      end
      in_rts = (idx < 6);
      in_op  = ops[(idx < 6) ? idx : 5];
      if (circ_rts && circ_rtr) got.push_back(circ_op);
      if (in_rts && in_rtr) idx++;
      step();
    end
    in_rts = 1'b0;
    total++; if (got.size() != 6) begin bad++; $display("FAIL fill_delivered got=%0d want=6", got.size()); end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      total++; if (got[i] !== ops[i]) begin bad++; $display("FAIL fill_order i%0d got=%h want=%h", i, got[i], ops[i]); end
    end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL fill_drain got=%0d want=0", fifo_count); end
  endtask

  task automatic test_head_blocking();
    logic [OP_W-1:0] c_op, l_op;
    c_op = mk_op(30, 40, 3, 8'h22, 4'hC);
    l_op = mk_op(31, 41, 4, 8'h33, 4'hA);
    circ_rtr = 1'b0; line_rtr = 1'b1;
    in_rts = 1'b1; in_op = c_op; step();
    in_op = l_op; step();
    in_rts = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (line_rts !== 1'b0 || circ_rts !== 1'b1) begin bad++; $display("FAIL block_stall c%0d got=%0h/%0h want line0/circ1", i, line_rts, circ_rts); end
      step();
    end
    circ_rtr = 1'b1;
    step();
    total++; if (line_rts !== 1'b1 || circ_rts !== 1'b0) begin bad++; $display("FAIL block_line_up got=%0h/%0h want line1/circ0", line_rts, circ_rts); end
    total++; if (line_op !== l_op) begin bad++; $display("FAIL block_line_op got=%h want=%h", line_op, l_op); end
    step();
    total++; if (line_rts !== 1'b0 || fifo_count !== 3'd0) begin bad++; $display("FAIL block_done got=%0h/%0d want=0/0", line_rts, fifo_count); end
  endtask

  task automatic test_drop();
    logic [OP_W-1:0] c_op;
    c_op = mk_op(60, 61, 7, 8'h44, 4'hC);
    circ_rtr = 1'b1; line_rtr = 1'b1;
    in_rts = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_op = (k < 3) ? mk_op(k, k, k, k, 4'h5) : c_op;
      step();
      total++; if (drop_cnt !== 8'(k)) begin bad++; $display("FAIL drop_cnt k%0d got=%0d want=%0d", k, drop_cnt, k); end
      if (k < 3) begin
        total++; if (circ_rts !== 1'b0 || line_rts !== 1'b0) begin bad++; $display("FAIL drop_rts k%0d got=%0h/%0h want=0/0", k, circ_rts, line_rts); end
      end
    end
    in_rts = 1'b0;
    total++; if (circ_rts !== 1'b1 || circ_op !== c_op) begin bad++; $display("FAIL drop_circ got=%0h/%h want=1/%h", circ_rts, circ_op, c_op); end
    step();
    total++; if (fifo_count !== 3'd0 || drop_cnt !== 8'd3) begin bad++; $display("FAIL drop_end got=%0d/%0d want=0/3", fifo_count, drop_cnt); end
  endtask

  task automatic test_drop_saturation();
    in_rts = 1'b1; in_op = mk_op(1, 2, 3, 4, 4'h0);
    for (int i = 0; i < 200; i++) step();
    total++; if (drop_cnt !== 8'd202) begin bad++; $display("FAIL sat_mid got=%0d want=202", drop_cnt); end
    for (int i = 0; i < 100; i++) step();
    in_rts = 1'b0;
    for (int i = 0; i < 3; i++) step();
    total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL sat_final got=%0d want=255", drop_cnt); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL sat_count got=%0d want=0", fifo_count); end
  endtask

  task automatic test_async_reset();
    logic [OP_W-1:0] n_op;
    n_op = mk_op(20, 21, 9, 8'h55, 4'hC);
    circ_rtr = 1'b0;
    in_rts = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_op = mk_op(7 + i, 0, 1, 8'h66, 4'hC);
      step();
    end
    in_rts = 1'b0;
    total++; if (fifo_count !== 3'd3) begin bad++; $display("FAIL arst_pre_count got=%0d want=3", fifo_count); end
    #3 rst_ = 1'b0;
    #1;
    total++; if (circ_rts !== 1'b0) begin bad++; $display("FAIL arst_rts got=%0h want=0", circ_rts); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL arst_count got=%0d want=0", fifo_count); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL arst_drop got=%0d want=0", drop_cnt); end
    total++; if (in_rtr !== 1'b0) begin bad++; $display("FAIL arst_in_rtr got=%0h want=0", in_rtr); end
    step();
    rst_ = 1'b1;
    in_op = n_op; in_rts = 1'b1; circ_rtr = 1'b1;
    step();
    in_rts = 1'b0;
    total++; if (circ_rts !== 1'b1 || circ_op !== n_op) begin bad++; $display("FAIL arst_first got=%0h/%h want=1/%h", circ_rts, circ_op, n_op); end
    step();
    total++; if (fifo_count !== 3'd0 || circ_rts !== 1'b0) begin bad++; $display("FAIL arst_drain got=%0d/%0h want=0/0", fifo_count, circ_rts); end
  endtask

  task automatic test_random();
    logic [OP_W-1:0] q [$];
    logic [63:0]     rnd;
    logic [3:0]      opc;
    logic            hold, acc, do_pop, hc, hl;
    int              exp_drop, sel;
    exp_drop = 0;
    hold = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        in_rts = ($urandom % 4) != 0;
        sel = $urandom % 5;
        opc = (sel < 2) ? 4'hC : (sel < 4) ? 4'hA : 4'($urandom);
        rnd = {$urandom, $urandom};
        in_op = {rnd[41:4], opc};
      end
      circ_rtr = ($urandom % 3) != 0;
      line_rtr = ($urandom % 3) != 0;
      hc = (q.size() > 0) && (q[0][3:0] == 4'hC);
      hl = (q.size() > 0) && (q[0][3:0] == 4'hA);
      total++; if (in_rtr !== (q.size() < DEPTH)) begin bad++; $display("FAIL rnd_in_rtr n%0d got=%0h want=%0h", n, in_rtr, q.size() < DEPTH); end
      total++; if (fifo_count !== 3'(q.size())) begin bad++; $display("FAIL rnd_count n%0d got=%0d want=%0d", n, fifo_count, q.size()); end
      total++; if (circ_rts !== hc || line_rts !== hl) begin bad++; $display("FAIL rnd_rts n%0d got=%0h/%0h want=%0h/%0h", n, circ_rts, line_rts, hc, hl); end
      total++; if (drop_cnt !== 8'(exp_drop)) begin bad++; $display("FAIL rnd_drop n%0d got=%0d want=%0d", n, drop_cnt, exp_drop); end
      if (hc) begin
        total++; if (circ_op !== q[0]) begin bad++; $display("FAIL rnd_circ_op n%0d got=%h want=%h", n, circ_op, q[0]); end
      end
      if (hl) begin
        total++; if (line_op !== q[0]) begin bad++; $display("FAIL rnd_line_op n%0d got=%h want=%h", n, line_op, q[0]); end
      end
      acc = in_rts && (q.size() < DEPTH);
      do_pop = (q.size() > 0) && (hc ? circ_rtr : hl ? line_rtr : 1'b1);
      if (q.size() > 0 && !hc && !hl && exp_drop < 255) exp_drop++;
      if (do_pop) void'(q.pop_front());
      if (acc) q.push_back(in_op);
      hold = in_rts && !acc;
      step();
    end
    in_rts = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_circle();
    test_back_to_back();
    test_fill_wrap();
    test_head_blocking();
    test_drop();
    test_drop_saturation();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gfx_op_dispatcher.md
# gfx_op_dispatcher

Command-side front end for the drawing engines. Buffers 42-bit drawing ops from the host command stream in a small FIFO, decodes the opcode, and presents each op to the matching engine over an rts/rtr handshake. The circle port feeds `circle_drawing_engine.in_op/in_rts/in_rtr` directly; the line port feeds the line engine. Ops with unknown opcodes are discarded and counted.

## Interface
- `DEPTH`, 4: FIFO entries; must be a power of two, ≥2.
- `OP_W`, 42: op width. Field layout, MSB first:
  - `xc[41:32]`
  - `yc[31:22]`
  - `r[21:12]`
  - `color[11:4]`
  - `opcode[3:0]`
- `CIRCLE_OPC`, 4'hC: opcode routed to the circle port.
- `LINE_OPC`, 4'hA: opcode routed to the line port.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_`  in  1  asynchronous, active-low reset.
- `in_op`  in  OP_W  op from the host.
- `in_rts`  in  1  host has an op.
- `in_rtr`  out  1  dispatcher can accept an op.
- `circ_op`  out  OP_W  op to the circle engine.
- `circ_rts`  out  1  circle op valid.
- `circ_rtr`  in  1  circle engine ready.
- `line_op`  out  OP_W  op to the line engine.
- `line_rts`  out  1  line op valid.
- `line_rtr`  in  1  line engine ready.
- `fifo_count`  out  $clog2(DEPTH)+1  entries held.
- `drop_cnt`  out  8  discarded-op count; saturates at 255.

## Operation
- Transfer rule: a transfer occurs on a rising edge where `rts && rtr` are both high. Data must be stable while `rts` is high.
- Push: on an `in_rts && in_rtr` edge, `in_op` is written at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
- Head decode uses `head = mem[rd_ptr]`, valid when `fifo_count != 0`:
  - opcode == CIRCLE_OPC: `circ_rts` = 1, `line_rts` = 0.
  - opcode == LINE_OPC: `line_rts` = 1, `circ_rts` = 0.
  - any other opcode: both rts = 0. The head is popped unconditionally on the next edge, and `drop_cnt` increments (holds at 255).
- `circ_op` and `line_op` both always drive `head`; only the relevant rts qualifies it.
- Pop: occurs on `circ_rts && circ_rtr`, `line_rts && line_rtr`, or a drop. At most one pop per cycle. `rd_ptr` increments modulo DEPTH.
- In-order: the head blocks the FIFO. A circle op waiting on `circ_rtr` = 0 stalls line ops queued behind it. No reordering.
- Count: `fifo_count` gets +1 on push only, −1 on pop only, unchanged on both or neither.
- `in_rtr` = `(fifo_count != DEPTH)`, from registered state only, with no combinational path from any rtr input. A push into a full FIFO is never accepted, even when a pop occurs in the same cycle.

## Timing
- Reset (`rst_` low, async):
  - `wr_ptr`, `rd_ptr`, `fifo_count`, `drop_cnt` = 0.
  - `circ_rts`, `line_rts` = 0.
  - `in_rtr` = 0 while `rst_` is low; it goes to 1 combinationally after release (count = 0).
  - `circ_op`/`line_op` are don't-care.
- Reset mid-operation flushes every queued op. An op being handshaked on the same edge as reset assertion is lost.
- Latency: an op pushed at edge N drives the target rts high from edge N (visible in cycle N+1). Earliest consume is at edge N+1. No bypass when empty.
- Throughput: one push and one pop per cycle sustained; the FIFO never drains below steady state when the engine holds rtr = 1.
- Drop: an invalid head occupies exactly one cycle, then pops.
- Empty: both rts = 0, no pop, and `drop_cnt` does not increment.
- Full: `in_rtr` = 0; the host must hold its op and `in_rts`.
- Wrap: pointers roll from DEPTH−1 to 0; data order is preserved across the wrap.
- All outputs are glitch-free functions of registers. `in_rtr`, `circ_rts`, `line_rts` depend only on `fifo_count`, `rd_ptr`, and memory.

## Test plan
- Single circle op:
  - Stimulus: after reset, push op 42'b0001100100_0001100100_0000001010_10101011_1100 (center 100,100, r=10, color 0xAB, opc C), with `circ_rtr` = 1.
  - Required: `circ_rts` high for exactly 1 cycle starting the cycle after push, `circ_op` equals the input, `fifo_count` returns 0 with `line_rts` = 0 throughout.
- Back-to-back, stalled engine:
  - Stimulus: push the same circle op twice consecutively with `circ_rtr` = 0 for 10 cycles, then 1.
  - Required: `fifo_count` = 2 and `circ_rts` held with `circ_op` stable during the stall; two transfers on consecutive edges afterward.
- Fill and wrap:
  - Stimulus: push 6 distinct circle ops (xc = 1..6) with `circ_rtr` = 0, then release.
  - Required: `in_rtr` falls after 4 accepted; ops 5–6 wait; all 6 delivered in order xc = 1..6; pointers wrap.
- Routing and head blocking:
  - Stimulus: push circle (opc C), then line (opc A), with `circ_rtr` = 0 and `line_rtr` = 1.
  - Required: `line_rts` stays 0 until the circle op transfers, then asserts the next cycle.
- Drop counting:
  - Stimulus: push 3 ops with opcode 0x5, then one circle op.
  - Required: each is dropped in 1 cycle, `drop_cnt` = 3, the circle op is delivered, and neither rts is asserted for the dropped ops.
  - Saturation: 300 drops leave `drop_cnt` = 255.
- Async reset mid-stream:
  - Stimulus: assert `rst_` between clock edges with 3 ops queued.
  - Required: `circ_rts` / `fifo_count` / `drop_cnt` go to 0 immediately without a clock edge, and the next pushed op is the first one delivered.
